// File: rtl/tron_ctrl_pkg.sv
// Shared encodings for the Tron 16-bit control unit: states, opcodes,
// bus sources and the decoded control bundle.
package tron_ctrl_pkg;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEMX  = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  typedef enum logic [2:0] {
    BUS_ALU   = 3'b000,
    BUS_SHIFT = 3'b001,
    BUS_MEM   = 3'b010,
    BUS_IMM   = 3'b011,
    BUS_PC    = 3'b100
  } bus_t;

  localparam logic [3:0] FLAG_UC = 4'b1110;

  typedef enum logic [3:0] {
    CL_NOP, CL_RTYPE, CL_ALUI, CL_SHIFT, CL_BCOND,
    CL_LOAD, CL_STORE, CL_JCOND, CL_JAL, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic [3:0]       aluOp;
    logic [1:0]       shiftOp;
    bus_t             busOp;
    logic [3:0]       flagOp;
    logic             immMUX;
    logic [WIDTH-1:0] immediate;
    iclass_t          iclass;
  } ctrl_t;

  function automatic logic [WIDTH-1:0] sext8(input logic [7:0] v);
    return {{(WIDTH-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure decode of the latched instruction word into the datapath control
// bundle; strobes are not generated here, only the instruction class.
module instr_decoder
  import tron_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0] ir,
  output ctrl_t            ctrl
);

  logic [3:0] op, ext;
  assign op  = ir[15:12];
  assign ext = ir[7:4];

  always_comb begin
    ctrl           = '0;
    ctrl.busOp     = BUS_ALU;
    ctrl.iclass    = CL_NOP;
    if (op == OP_RTYPE) begin
      ctrl.iclass = CL_RTYPE;
      ctrl.aluOp  = ext;
    end else if (!op[3] && op[1:0] != 2'b00) begin
      // 0001-0011 and 0101-0111: immediate forms share the low three opcode bits
      ctrl.iclass    = CL_ALUI;
      ctrl.aluOp     = {1'b0, op[2:0]};
      ctrl.immMUX    = 1'b1;
      ctrl.immediate = sext8(ir[7:0]);
    end else if (op == OP_SHIFT) begin
      ctrl.iclass  = CL_SHIFT;
      ctrl.shiftOp = ir[5:4];
      ctrl.busOp   = BUS_SHIFT;
      if (ir[6]) begin
        ctrl.immMUX    = 1'b1;
        ctrl.immediate = {{(WIDTH-4){1'b0}}, ir[3:0]};
      end
    end else if (op == OP_BCOND) begin
      ctrl.iclass    = CL_BCOND;
      ctrl.flagOp    = ir[11:8];
      ctrl.immediate = sext8(ir[7:0]);
    end else if (op == OP_MEMX) begin
      case (ext)
        EXT_LOAD: begin
          ctrl.iclass = CL_LOAD;
          ctrl.busOp  = BUS_MEM;
        end
        EXT_STORE: ctrl.iclass = CL_STORE;
        EXT_JCOND: begin
          ctrl.iclass = CL_JCOND;
          ctrl.flagOp = ir[11:8];
        end
        EXT_JAL: begin
          ctrl.iclass = CL_JAL;
          ctrl.busOp  = BUS_PC;
          ctrl.flagOp = FLAG_UC;
        end
        default: ctrl.iclass = CL_NOP;
      endcase
    end else if (op == OP_HALT) begin
      ctrl.iclass = CL_HALT;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle Tron control unit: fetch/decode/exec/mem sequencing with the
// instruction register and all datapath strobe gating.
module control_fsm
  import tron_ctrl_pkg::*;
#(
  parameter int WIDTH   = tron_ctrl_pkg::WIDTH,
  parameter int REGBITS = tron_ctrl_pkg::REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   instr,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               addr_sel,
  output logic               memWrite,
  output logic [7:0]         instructionOp,
  output logic [WIDTH-1:0]   immediate,
  output logic [REGBITS-1:0] regAddA,
  output logic [REGBITS-1:0] regAddB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         shiftOp,
  output logic [2:0]         busOp,
  output logic [3:0]         flagOp,
  output logic               immMUX,
  output logic               regWrite,
  output logic               flagWrite,
  output logic               pcAdd,
  output logic               pcJump,
  output logic               pcBranch,
  output logic [2:0]         state_dbg
);

  state_t           state, stateNext;
  logic [WIDTH-1:0] ir;
  ctrl_t            ctrl;

  instr_decoder uDec (.ir(ir), .ctrl(ctrl));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= stateNext;
      if (state == S_FETCH && mem_ready) ir <= instr;
    end
  end

  always_comb begin
    stateNext     = state;
    mem_req       = 1'b0;
    addr_sel      = 1'b0;
    memWrite      = 1'b0;
    regWrite      = 1'b0;
    flagWrite     = 1'b0;
    pcAdd         = 1'b0;
    pcJump        = 1'b0;
    pcBranch      = 1'b0;
    instructionOp = {ir[15:12], ir[7:4]};
    regAddA       = ir[3:0];
    regAddB       = ir[11:8];
    ALUOp         = ctrl.aluOp;
    shiftOp       = ctrl.shiftOp;
    busOp         = ctrl.busOp;
    flagOp        = ctrl.flagOp;
    immMUX        = ctrl.immMUX;
    immediate     = ctrl.immediate;
    state_dbg     = state;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) stateNext = S_DECODE;
      end
      S_DECODE: stateNext = S_EXEC;
      S_EXEC: begin
        stateNext = S_FETCH;
        case (ctrl.iclass)
          CL_RTYPE, CL_ALUI: begin
            regWrite  = 1'b1;
            flagWrite = 1'b1;
            pcAdd     = 1'b1;
          end
          CL_SHIFT: begin
            regWrite = 1'b1;
            pcAdd    = 1'b1;
          end
          CL_BCOND: pcBranch = 1'b1;
          CL_JCOND: pcJump = 1'b1;
          CL_JAL: begin
            regWrite = 1'b1;
            pcJump   = 1'b1;
          end
          CL_LOAD, CL_STORE: stateNext = S_MEM;
          CL_HALT: stateNext = S_HALT;
          default: pcAdd = 1'b1;
        endcase
      end
      S_MEM: begin
        // Store data stays on the bus for the whole access; the PC only
        // moves once memory accepts it
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        memWrite = (ctrl.iclass == CL_STORE);
        if (mem_ready) begin
          regWrite  = (ctrl.iclass == CL_LOAD);
          pcAdd     = 1'b1;
          stateNext = S_FETCH;
        end
      end
      S_HALT: stateNext = S_HALT;
      default: stateNext = S_FETCH;
    endcase
    if (reset) begin
      mem_req       = 1'b0;
      addr_sel      = 1'b0;
      memWrite      = 1'b0;
      regWrite      = 1'b0;
      flagWrite     = 1'b0;
      pcAdd         = 1'b0;
      pcJump        = 1'b0;
      pcBranch      = 1'b0;
      instructionOp = '0;
      regAddA       = '0;
      regAddB       = '0;
      ALUOp         = '0;
      shiftOp       = '0;
      busOp         = '0;
      flagOp        = '0;
      immMUX        = 1'b0;
      immediate     = '0;
      state_dbg     = '0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed + randomized bench for control_fsm against an instruction-level
// reference model of expected decode fields and per-phase strobes.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        mem_req, addr_sel, memWrite;
  logic [7:0]  instructionOp;
  logic [15:0] immediate;
  logic [3:0]  regAddA, regAddB, ALUOp, flagOp;
  logic [1:0]  shiftOp;
  logic [2:0]  busOp, state_dbg;
  logic        immMUX, regWrite, flagWrite, pcAdd, pcJump, pcBranch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .addr_sel(addr_sel), .memWrite(memWrite),
    .instructionOp(instructionOp), .immediate(immediate),
    .regAddA(regAddA), .regAddB(regAddB), .ALUOp(ALUOp), .shiftOp(shiftOp),
    .busOp(busOp), .flagOp(flagOp), .immMUX(immMUX), .regWrite(regWrite),
    .flagWrite(flagWrite), .pcAdd(pcAdd), .pcJump(pcJump),
    .pcBranch(pcBranch), .state_dbg(state_dbg)
  );

  // strobe order: regWrite flagWrite memWrite pcAdd pcJump pcBranch
  logic [5:0] strb;
  assign strb = {regWrite, flagWrite, memWrite, pcAdd, pcJump, pcBranch};

  typedef struct {
    logic [3:0]  alu;   logic aluC;
    logic [1:0]  sh;    logic shC;
    logic [2:0]  bus;   logic busC;
    logic [3:0]  flag;  logic flagC;
    logic        imm;   logic immC;
    logic [15:0] immv;  logic immvC;
    logic [5:0]  strobes;
    logic        isMem, isStore, isHalt;
  } exp_t;

  function automatic logic [15:0] sx(input int w);
    int v;
    v = w & 255;
    if (v >= 128) v -= 256;
    return 16'(v);
  endfunction

  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int op, ext;
    op  = int'(w) >> 12;
    ext = (int'(w) >> 4) & 15;
    e = '{default: '0};
    e.strobes = 6'b000100;
    if (op == 0) begin
      e.alu = 4'(ext); e.aluC = 1; e.imm = 0; e.immC = 1;
      e.bus = 3'b000; e.busC = 1; e.strobes = 6'b110100;
    end else if (op inside {1, 2, 3, 5, 6, 7}) begin
      e.alu = 4'(op); e.aluC = 1; e.imm = 1; e.immC = 1;
      e.immv = sx(int'(w)); e.immvC = 1;
      e.bus = 3'b000; e.busC = 1; e.strobes = 6'b110100;
    end else if (op == 8) begin
      e.sh = 2'(ext & 3); e.shC = 1; e.bus = 3'b001; e.busC = 1;
      e.strobes = 6'b100100; e.immC = 1;
      if ((ext & 4) != 0) begin
        e.imm = 1; e.immv = 16'(int'(w) & 15); e.immvC = 1;
      end else e.imm = 0;
    end else if (op == 12) begin
      e.flag = 4'((int'(w) >> 8) & 15); e.flagC = 1;
      e.immv = sx(int'(w)); e.immvC = 1; e.strobes = 6'b000001;
    end else if (op == 4) begin
      if (ext == 0 || ext == 4) begin
        e.isMem = 1; e.isStore = (ext == 4); e.strobes = 6'b000000;
      end else if (ext == 12) begin
        e.flag = 4'((int'(w) >> 8) & 15); e.flagC = 1; e.strobes = 6'b000010;
      end else if (ext == 8) begin
        e.flag = 4'd14; e.flagC = 1; e.bus = 3'b100; e.busC = 1;
        e.strobes = 6'b100010;
      end
    end else if (op == 15) begin
      e.isHalt = 1; e.strobes = 6'b000000;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] randInstr();
    logic [3:0] a, b, e, op;
    int k, t;
    a = 4'($urandom); b = 4'($urandom); e = 4'($urandom);
    k = $urandom_range(0, 9);
    t = $urandom_range(0, 5);
    case (k)
      0: op = 4'h0;
      1, 2: op = (t < 3) ? 4'(t + 1) : 4'(t + 2);
      3: op = 4'h8;
      4: op = 4'hC;
      5: begin op = 4'h4; e = 4'h0; end
      6: begin op = 4'h4; e = 4'h4; end
      7: begin op = 4'h4; e = (t < 3) ? 4'hC : 4'h8; end
      8: op = 4'h4;
      default: op = (t < 3) ? 4'(9 + t) : 4'(10 + (t % 5));
    endcase
    return {op, b, e, a};
  endfunction

  // Runs one instruction end to end; abortMem asserts reset in the MEM phase
  task automatic runInstr(input logic [15:0] w, input int fW, input int mW,
                          input bit abortMem);
    exp_t m;
    int pcCnt;
    m = model(w);
    pcCnt = 0;
    for (int i = 0; i < fW; i++) begin
      mem_ready = 0; instr = 16'($urandom);
      @(negedge clk);
      chk("fetchWaitState", state_dbg, 0);
      chk("fetchWaitReq", {mem_req, addr_sel}, 2'b10);
      chk("fetchWaitStrb", strb, 0);
      tick();
    end
    mem_ready = 1; instr = w;
    @(negedge clk);
    chk("fetchState", state_dbg, 0);
    chk("fetchReq", {mem_req, addr_sel, strb}, 8'b1000_0000);
    tick();
    mem_ready = 1'($urandom); instr = 16'($urandom);
    @(negedge clk);
    chk("decState", state_dbg, 1);
    chk("decStrb", {mem_req, strb}, 0);
    chk("decInstrOp", instructionOp, ((int'(w) >> 12) << 4) | ((int'(w) >> 4) & 15));
    chk("decRegA", regAddA, int'(w) & 15);
    chk("decRegB", regAddB, (int'(w) >> 8) & 15);
    tick();
    mem_ready = 1'($urandom);
    @(negedge clk);
    chk("execState", state_dbg, 2);
    chk("execStrb", strb, m.strobes);
    chk("execReq", mem_req, 0);
    if (m.aluC)  chk("ALUOp", ALUOp, m.alu);
    if (m.shC)   chk("shiftOp", shiftOp, m.sh);
    if (m.busC)  chk("busOp", busOp, m.bus);
    if (m.flagC) chk("flagOp", flagOp, m.flag);
    if (m.immC)  chk("immMUX", immMUX, m.imm);
    if (m.immvC) chk("immediate", immediate, m.immv);
    pcCnt += $countones({pcAdd, pcJump, pcBranch});
    tick();
    if (m.isHalt) return;
    if (m.isMem) begin
      for (int i = 0; i < mW; i++) begin
        mem_ready = 0;
        @(negedge clk);
        chk("memWaitState", state_dbg, 3);
        chk("memWaitReq", {mem_req, addr_sel}, 2'b11);
        chk("memWaitStrb", strb, {2'b00, m.isStore, 3'b000});
        tick();
      end
      if (abortMem) begin
        reset = 1; mem_ready = 1'($urandom);
        @(negedge clk);
        chk("rstMemStrb", {mem_req, addr_sel, strb}, 0);
        chk("rstMemState", state_dbg, 0);
        tick();
        reset = 0; mem_ready = 0;
        @(negedge clk);
        chk("postRstState", state_dbg, 0);
        chk("postRstReq", {mem_req, strb}, 7'b1000000);
        tick();
        return;
      end
      mem_ready = 1;
      @(negedge clk);
      chk("memState", state_dbg, 3);
      chk("memStrb", strb, {~m.isStore, 1'b0, m.isStore, 3'b100});
      if (!m.isStore) chk("memBusOp", busOp, 3'b010);
      pcCnt += $countones({pcAdd, pcJump, pcBranch});
      tick();
    end
    chk("pcStrobeCount", pcCnt, 1);
  endtask

  initial begin
    reset = 1; mem_ready = 0; instr = 16'h0;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom); instr = 16'($urandom);
      @(negedge clk);
      chk("rstOutputs", {mem_req, addr_sel, strb, state_dbg, instructionOp}, 0);
      chk("rstFields", {immediate, busOp, ALUOp, immMUX}, 0);
      tick();
    end
    reset = 0;
    runInstr(16'h0251, 0, 0, 0);
    runInstr(16'h53FF, 0, 0, 0);
    runInstr(16'h4203, 1, 3, 0);
    runInstr(16'h4743, 0, 2, 0);
    runInstr(16'hC0FE, 2, 0, 0);
    runInstr(16'h4A8C, 0, 0, 0);
    runInstr(16'h8563, 0, 0, 0);
    for (int n = 0; n < 60; n++)
      runInstr(randInstr(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    runInstr(16'h4743, 0, 1, 1);
    runInstr(16'h0251, 0, 0, 0);
    runInstr(16'hF000, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom); instr = 16'($urandom);
      @(negedge clk);
      chk("haltState", state_dbg, 4);
      chk("haltStrb", {mem_req, addr_sel, strb}, 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
